// File: rtl/onchip_mem_arbiter_if.sv
// onchip_mem_arbiter_if: Avalon-MM-style requester port with waitrequest and readdatavalid
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin arbiter with bounded burst lock sharing one 1-cycle-latency SRAM
module onchip_mem_arbiter #(
    parameter int          ADDR_W    = 15,
    parameter int unsigned DEPTH     = 20000,
    parameter int          MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    onchip_mem_arbiter_if.slave m0,
    onchip_mem_arbiter_if.slave m1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic [7:0]        err_count
);
    localparam int BW = $clog2(MAX_BURST + 1);

    logic              last_owner;
    logic [BW-1:0]     burst_cnt;
    logic              req0, req1, keep, gnt0, gnt1, active, owner, wr, rd, oor;
    logic [ADDR_W-1:0] addr;
    logic              rd_valid, rd_owner, rd_oor;

    // burst_cnt == 0 only after reset, so no lock exists until the first transfer
    always_comb begin
        req0 = reset_n & (m0.read | m0.write);
        req1 = reset_n & (m1.read | m1.write);
        keep = (burst_cnt != '0) && (burst_cnt < BW'(MAX_BURST));
        gnt1 = req1 & (!req0 | (last_owner ? keep : !keep));
        gnt0 = req0 & !gnt1;
        active = gnt0 | gnt1;
        owner = gnt1;
        addr = owner ? m1.address : m0.address;
        wr = owner ? m1.write : m0.write;
        rd = (owner ? m1.read : m0.read) & !wr;
        oor = 32'(addr) >= DEPTH;
        mem_address = addr;
        mem_byteenable = owner ? m1.byteenable : m0.byteenable;
        mem_writedata = owner ? m1.writedata : m0.writedata;
        mem_chipselect = active & !oor;
        mem_write = mem_chipselect & wr;
        m0.waitrequest = !gnt0;
        m1.waitrequest = !gnt1;
        m0.readdatavalid = rd_valid & !rd_owner;
        m1.readdatavalid = rd_valid & rd_owner;
        m0.readdata = rd_oor ? 32'h0 : mem_readdata;
        m1.readdata = rd_oor ? 32'h0 : mem_readdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_owner <= 1'b1;
            burst_cnt  <= '0;
            rd_valid   <= 1'b0;
            rd_owner   <= 1'b0;
            rd_oor     <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            if (active) begin
                last_owner <= owner;
                burst_cnt  <= (owner != last_owner) ? BW'(1) :
                              (burst_cnt == BW'(MAX_BURST)) ? burst_cnt : burst_cnt + BW'(1);
            end
            rd_valid <= active & rd;
            rd_owner <= owner;
            rd_oor   <= oor;
            if (active && oor && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed scoreboard bench with an SRAM model on the memory side
module tb_onchip_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata, mem_readdata, mask;
    logic [7:0]  err_count;
    logic [31:0] sram [0:32767];
    int          checks = 0, failures = 0, cyc = 0;

    typedef struct {bit port; logic [31:0] data; int due;} rsp_t;
    rsp_t q[$];

    onchip_mem_arbiter_if #(.ADDR_W(15)) m0_if();
    onchip_mem_arbiter_if #(.ADDR_W(15)) m1_if();

    onchip_mem_arbiter #(.ADDR_W(15), .DEPTH(20000), .MAX_BURST(8)) dut (
        .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mask = {{8{mem_byteenable[3]}}, {8{mem_byteenable[2]}}, {8{mem_byteenable[1]}}, {8{mem_byteenable[0]}}};
    always @(posedge clk)
        if (mem_chipselect) begin
            if (mem_write) sram[mem_address] <= (sram[mem_address] & ~mask) | (mem_writedata & mask);
            else mem_readdata <= sram[mem_address];
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && cyc > q[0].due) begin
            chk("rdv_missing", 32'(cyc), 32'(q[0].due));
            void'(q.pop_front());
        end
        if (m0_if.readdatavalid === 1'b1 || m1_if.readdatavalid === 1'b1) begin
            if (q.size() == 0) chk("rdv_unexpected", {30'b0, m1_if.readdatavalid, m0_if.readdatavalid}, 32'd0);
            else begin
                rsp_t e;
                e = q.pop_front();
                chk("rdv_port", {30'b0, m1_if.readdatavalid, m0_if.readdatavalid}, e.port ? 32'd2 : 32'd1);
                chk("rdv_cycle", 32'(cyc), 32'(e.due));
                chk("rdata", e.port ? m1_if.readdata : m0_if.readdata, e.data);
            end
        end
    end

    task automatic idle();
        m0_if.read = 0; m0_if.write = 0;
        m1_if.read = 0; m1_if.write = 0;
    endtask

    task automatic xfer(input bit p, input logic rd, input logic wr, input logic [14:0] a,
                        input logic [3:0] be, input logic [31:0] d, input logic [31:0] exp, input logic cs);
        int n;
        if (p) begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.byteenable = be; m1_if.writedata = d;
        end else begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.byteenable = be; m0_if.writedata = d;
        end
        n = 0;
        @(negedge clk);
        while ((p ? m1_if.waitrequest : m0_if.waitrequest) && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("accept", 32'(p ? m1_if.waitrequest : m0_if.waitrequest), 32'd0);
        chk("chipselect", 32'(mem_chipselect), 32'(cs));
        chk("mem_write", 32'(mem_write), 32'(cs & wr));
        if (rd && !wr) q.push_back('{p, exp, cyc + 1});
        @(posedge clk); #1;
        idle();
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        m0_if.address = 0; m0_if.byteenable = 4'hF; m0_if.writedata = 0;
        m1_if.address = 0; m1_if.byteenable = 4'hF; m1_if.writedata = 0;
        idle();
        // request held through reset must not be accepted
        m0_if.read = 1; m0_if.address = 15'd20000;
        repeat (3) begin
            @(negedge clk);
            chk("rst_wait0", 32'(m0_if.waitrequest), 32'd1);
            chk("rst_cs", 32'(mem_chipselect), 32'd0);
            chk("rst_rdv", {30'b0, m1_if.readdatavalid, m0_if.readdatavalid}, 32'd0);
            chk("rst_err", 32'(err_count), 32'd0);
        end
        reset_n = 1;
        #1;
        chk("first_grant", 32'(m0_if.waitrequest), 32'd0);
        q.push_back('{1'b0, 32'h0, cyc + 1});
        @(posedge clk); #1;
        idle();

        xfer(0, 0, 1, 15'h0010, 4'hF, 32'hDEADBEEF, 32'h0, 1);
        xfer(0, 1, 0, 15'h0010, 4'hF, 32'h0, 32'hDEADBEEF, 1);
        xfer(0, 0, 1, 15'd5, 4'hF, 32'h11223344, 32'h0, 1);
        xfer(1, 0, 1, 15'd5, 4'b0010, 32'hAABBCCDD, 32'h0, 1);
        xfer(0, 1, 0, 15'd5, 4'hF, 32'h0, 32'h1122CC44, 1);
        xfer(1, 0, 1, 15'd19999, 4'hF, 32'hCAFEF00D, 32'h0, 1);
        xfer(1, 1, 0, 15'd19999, 4'hF, 32'h0, 32'hCAFEF00D, 1);
        xfer(0, 1, 1, 15'h0010, 4'hF, 32'h12345678, 32'h0, 1);
        xfer(1, 1, 0, 15'h0010, 4'hF, 32'h0, 32'h12345678, 1);
        drain();

        reset_n = 0;
        m0_if.write = 1; m0_if.address = 15'd100;
        m1_if.write = 1; m1_if.address = 15'd200;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("fair_m0", 32'(m0_if.waitrequest), 32'(((k / 8) % 2) != 0));
            chk("fair_m1", 32'(m1_if.waitrequest), 32'(((k / 8) % 2) != 1));
            chk("fair_cs", 32'(mem_chipselect), 32'd1);
        end
        @(posedge clk); #1;
        idle();

        do_reset();
        m0_if.address = 15'd300; m1_if.address = 15'd301;
        for (int k = 0; k < 15; k++) begin
            int g;
            m0_if.write = (k != 5);
            m1_if.write = (k >= 3);
            g = (k >= 5 && k <= 12) ? 1 : 0;
            @(negedge clk);
            chk("lock_m0", 32'(m0_if.waitrequest), 32'(g != 0));
            chk("lock_m1", 32'(m1_if.waitrequest), 32'(g != 1));
            @(posedge clk); #1;
        end
        idle();
        drain();

        do_reset();
        xfer(1, 1, 0, 15'd20000, 4'hF, 32'h0, 32'h0, 0);
        xfer(1, 0, 1, 15'd20001, 4'hF, 32'h55555555, 32'h0, 0);
        chk("err_two", 32'(err_count), 32'd2);
        for (int i = 0; i < 300; i++)
            xfer(1, (i % 3) == 0, (i % 3) != 0, 15'(20000 + i % 100), 4'hF, 32'(i), 32'h0, 0);
        chk("err_sat", 32'(err_count), 32'd255);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-requester arbiter sharing the single-port 32-bit on-chip SRAM (15-bit word address, 20000 words, 1-cycle read latency).
- Requester 0 is the D8M camera frame writer; requester 1 is the Nios II-side pose/score reader.
- Arbitration is round-robin with a bounded burst lock, so a streaming master cannot starve the other.
- Each requester sees an Avalon-MM-style port with waitrequest and readdatavalid; the memory side drives the SRAM port directly.

Parameters:
- ADDR_W, 15, word address width.
- DEPTH, 20000, number of valid words; addresses >= DEPTH are out of range.
- MAX_BURST, 8, maximum consecutive accepted transfers by one owner while the other requester is waiting (must be >= 1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- m0_address  in  ADDR_W  requester 0 word address.
- m0_byteenable  in  4  requester 0 byte lanes.
- m0_read  in  1  requester 0 read request.
- m0_write  in  1  requester 0 write request.
- m0_writedata  in  32  requester 0 write data.
- m0_waitrequest  out  1  high = request not accepted this cycle.
- m0_readdata  out  32  requester 0 read data.
- m0_readdatavalid  out  1  requester 0 read data valid, 1-cycle pulse.
- m1_*  same set as m0_*  requester 1.
- mem_address  out  ADDR_W  to SRAM.
- mem_byteenable  out  4  to SRAM.
- mem_chipselect  out  1  to SRAM.
- mem_write  out  1  to SRAM.
- mem_writedata  out  32  to SRAM.
- mem_readdata  in  32  from SRAM; valid the cycle after the address is presented.
- err_count  out  8  saturating count of out-of-range accesses.

Behaviour:
- Request: mN_req = mN_read | mN_write. If read and write are both high, the access is a write; no read response is produced.
- Grant is combinational from the current requests and registered state (last_owner, burst_cnt). At most one grant per cycle.
- Granted requester: mN_waitrequest = 0 and the transfer is accepted that cycle. Every other requesting port: waitrequest = 1. An idle port's waitrequest is don't-care; drive it 1.
- Grant rules:
  - Only one requester: it is granted.
  - Both requesting, last_owner also requesting, and burst_cnt < MAX_BURST: last_owner keeps the grant.
  - Otherwise: the non-last_owner requester is granted.
- State update on an accepted transfer:
  - Same owner as last_owner: burst_cnt increments, saturating at MAX_BURST.
  - Different owner: last_owner is updated and burst_cnt = 1.
  - No transfer: state holds. An owner's idle cycle therefore releases the lock immediately if the other requester is waiting.
- Memory side in the grant cycle: mem_address, mem_byteenable and mem_writedata are muxed from the owner. mem_chipselect = 1 only if the address < DEPTH. mem_write = chipselect & write. When idle, chipselect = 0 and write = 0.
- Read latency is exactly 1:
  - Registered pipe holds {valid, owner, oor}.
  - Next cycle, readdatavalid pulses on the owner's port.
  - readdata = mem_readdata, or 32'h0 if the access was out of range.
  - Both mN_readdata ports are driven from mem_readdata (muxed); contents are don't-care when not valid.
- Out of range (address >= DEPTH):
  - Transfer is accepted with no SRAM access.
  - Write is dropped; read returns 0 with normal timing.
  - err_count increments by 1, saturating at 255.
- Back-to-back: one accepted transfer per cycle, full throughput. A read response and a new acceptance may occur in the same cycle.
- Synchronous reset (reset_n low at a clk edge):
  - Outputs: all waitrequest = 1, readdatavalid = 0, mem_chipselect = 0, mem_write = 0, err_count = 0.
  - State: last_owner = 1 (so m0 wins the first contention), burst_cnt = 0, read pipe cleared.
  - A read accepted in the cycle before reset gets no response.
  - While reset_n is low, no transfer is accepted.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles with m0_read = 1 -> waitrequest = 1, mem_chipselect = 0. After release, m0 is granted on the first cycle.
- Single read: m0 writes 0xDEADBEEF to addr 0x0010 with byteenable 4'hF, then reads 0x0010 -> m0_readdatavalid is high exactly 1 cycle after acceptance with 0xDEADBEEF. m1_readdatavalid stays 0.
- Byte lanes: write 0x11223344 to 5, then 0xAABBCCDD with byteenable 4'b0010, then read 5 -> 0x1122CC44.
- Burst fairness, MAX_BURST = 8: both ports hold write requests continuously from reset -> grant sequence is m0 ×8, m1 ×8, m0 ×8, ...; no gaps in mem_chipselect.
- Lock release: m0 requests continuously while m1 requests from cycle 3 and m0 drops for 1 cycle at cycle 5 -> m1 is granted at cycle 5, and burst_cnt restarts at 1.
- Out of range: m1 reads address 20000 and writes 20001 -> read returns 0x0 with valid 1 cycle later, mem_chipselect = 0 for both, err_count = 2. After 300 further such accesses, err_count = 255.
